// File: rtl/pit_pkg.sv
// Shared types and constants for the programmable interval timer.
package pit_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        RW_LATCH = 2'b00,
        RW_LSB   = 2'b01,
        RW_MSB   = 2'b10,
        RW_BOTH  = 2'b11
    } rw_e;

    // Byte port index = {word address, byte lane}
    localparam logic [1:0] PORT_CH0  = 2'd0;
    localparam logic [1:0] PORT_CH1  = 2'd1;
    localparam logic [1:0] PORT_CH2  = 2'd2;
    localparam logic [1:0] PORT_CTRL = 2'd3;

    // Codes 6/7 alias 2/3; 1, 4 and 5 collapse to mode 0.
    function automatic mode_e decode_mode(input logic [2:0] code);
        case (code[1:0])
            2'b10:   return MODE2;
            2'b11:   return MODE3;
            default: return MODE0;
        endcase
    endfunction

endpackage

// File: rtl/pit_channel.sv
// One timer channel: reload/count registers, mode behaviour, read latch and
// the LSB/MSB byte pointer shared by reads and writes.
module pit_channel
    import pit_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       gate_i,
    input  logic       cfg_wr_i,
    input  logic [1:0] cfg_rw_i,
    input  logic [2:0] cfg_mode_i,
    input  logic       latch_i,
    input  logic       data_wr_i,
    input  logic [7:0] data_i,
    input  logic       rd_i,
    output logic [7:0] rd_byte_o,
    output logic       out_o
);

    localparam int W = COUNT_WIDTH;

    mode_e          mode_q, mode_d, cfg_mode;
    rw_e            rw_q, rw_d;
    logic [W-1:0]   count_q, count_d, reload_q, reload_d, latch_q, latch_d;
    logic [W-1:0]   sq_low, sq_high;
    logic           latched_q, latched_d, ptr_q, ptr_d, null_q, null_d;
    logic           load_pend_q, load_pend_d, out_q, out_d, reload_done;
    logic [15:0]    reload16, cur16, rd_val;

    assign cfg_mode = decode_mode(cfg_mode_i);
    // Square wave: odd reloads split into N+1 (high phase) and N-1 (low phase)
    assign sq_low   = {reload_q[W-1:1], 1'b0};
    assign sq_high  = sq_low + (reload_q[0] ? W'(2) : W'(0));
    assign cur16    = 16'(reload_q);
    assign rd_val   = latched_q ? 16'(latch_q) : 16'(count_q);
    assign out_o    = out_q;

    always_comb begin
        case (rw_q)
            RW_LSB:  rd_byte_o = rd_val[7:0];
            RW_MSB:  rd_byte_o = rd_val[15:8];
            default: rd_byte_o = ptr_q ? rd_val[15:8] : rd_val[7:0];
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        rw_d        = rw_q;
        count_d     = count_q;
        reload_d    = reload_q;
        latch_d     = latch_q;
        latched_d   = latched_q;
        ptr_d       = ptr_q;
        null_d      = null_q;
        load_pend_d = load_pend_q;
        out_d       = out_q;
        reload16    = cur16;
        reload_done = 1'b0;

        if (tick_i) begin
            if (load_pend_q) begin
                count_d     = (mode_q == MODE3) ? (out_q ? sq_high : sq_low) : reload_q;
                null_d      = 1'b0;
                load_pend_d = 1'b0;
            end else if (!null_q && gate_i) begin
                case (mode_q)
                    MODE2: begin
                        if (count_q == W'(1)) begin
                            count_d = reload_q;
                            out_d   = 1'b1;
                        end else begin
                            count_d = count_q - W'(1);
                            out_d   = (count_q != W'(2));
                        end
                    end
                    MODE3: begin
                        if (count_q == W'(2)) begin
                            out_d   = ~out_q;
                            count_d = out_q ? sq_low : sq_high;
                        end else begin
                            count_d = count_q - W'(2);
                        end
                    end
                    default: begin
                        count_d = count_q - W'(1);
                        if (count_q == W'(1)) out_d = 1'b1;
                    end
                endcase
            end
        end

        if (rd_i) begin
            if (rw_q == RW_BOTH) begin
                ptr_d = ~ptr_q;
                if (ptr_q) latched_d = 1'b0;
            end else begin
                latched_d = 1'b0;
            end
        end

        if (latch_i && !latched_q) begin
            latch_d   = count_q;
            latched_d = 1'b1;
        end

        if (cfg_wr_i) begin
            mode_d      = cfg_mode;
            rw_d        = rw_e'(cfg_rw_i);
            ptr_d       = 1'b0;
            latched_d   = 1'b0;
            null_d      = 1'b1;
            load_pend_d = 1'b0;
            out_d       = (cfg_mode != MODE0);
        end

        if (data_wr_i) begin
            case (rw_q)
                RW_LSB: begin
                    reload16    = {8'h00, data_i};
                    reload_done = 1'b1;
                end
                RW_MSB: begin
                    reload16    = {data_i, 8'h00};
                    reload_done = 1'b1;
                end
                default: begin
                    if (!ptr_q) begin
                        reload16 = {cur16[15:8], data_i};
                        ptr_d    = 1'b1;
                    end else begin
                        reload16    = {data_i, cur16[7:0]};
                        ptr_d       = 1'b0;
                        reload_done = 1'b1;
                    end
                end
            endcase
            reload_d = reload16[W-1:0];
            if (reload_done) load_pend_d = 1'b1;
            if (mode_q == MODE0) out_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= MODE0;
            rw_q        <= RW_BOTH;
            count_q     <= '0;
            reload_q    <= '0;
            latch_q     <= '0;
            latched_q   <= 1'b0;
            ptr_q       <= 1'b0;
            null_q      <= 1'b1;
            load_pend_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            rw_q        <= rw_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            latch_q     <= latch_d;
            latched_q   <= latched_d;
            ptr_q       <= ptr_d;
            null_q      <= null_d;
            load_pend_q <= load_pend_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: rtl/pit_timer.sv
// Programmable interval timer top: pit_clk synchroniser, byte-lane bus decode
// and up to three counter channels.
module pit_timer
    import pit_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pit_clk,
    input  logic                    cs,
    input  logic                    data_m_access,
    input  logic                    data_m_wr_en,
    input  logic [1:1]              data_m_addr,
    input  logic [1:0]              data_m_bytesel,
    input  logic [15:0]             data_m_data_in,
    output logic [15:0]             data_m_data_out,
    output logic                    data_m_ack,
    input  logic [NUM_CHANNELS-1:0] gate,
    output logic [NUM_CHANNELS-1:0] out
);

    logic        sync1_q, sync2_q, edge_q, tick;
    logic        bus_acc, bus_wr, bus_rd, rd_valid, ctrl_wr;
    logic [1:0]  ctrl_sel, ctrl_rw, rd_port;
    logic [2:0]  ctrl_mode;
    logic [7:0]  rd_bytes [4];
    logic [15:0] data_out_q;
    logic        ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= pit_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign tick      = sync2_q & ~edge_q;

    assign bus_acc   = cs & data_m_access;
    assign bus_wr    = bus_acc & data_m_wr_en;
    assign bus_rd    = bus_acc & ~data_m_wr_en;
    assign ctrl_sel  = data_m_data_in[15:14];
    assign ctrl_rw   = data_m_data_in[13:12];
    assign ctrl_mode = data_m_data_in[11:9];
    // Control writes naming channel 3 or an absent channel are discarded
    assign ctrl_wr   = bus_wr & data_m_addr[1] & data_m_bytesel[1]
                     & (ctrl_sel != 2'b11) & (int'(ctrl_sel) < NUM_CHANNELS);

    // Lane 0 wins when both lanes are read together
    assign rd_valid  = bus_rd & (|data_m_bytesel);
    assign rd_port   = {data_m_addr[1], ~data_m_bytesel[0]};
    assign rd_bytes[PORT_CTRL] = 8'h00;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam bit ADDR_BIT = (gi >= 2);
        localparam int LANE     = gi % 2;
        if (gi < NUM_CHANNELS) begin : g_present
            logic data_wr, cfg_wr, latch_cmd, rd_sel;
            logic [7:0] wr_byte;
            assign wr_byte   = (LANE != 0) ? data_m_data_in[15:8] : data_m_data_in[7:0];
            assign data_wr   = bus_wr & (data_m_addr[1] == ADDR_BIT) & data_m_bytesel[LANE];
            assign cfg_wr    = ctrl_wr & (ctrl_sel == 2'(gi)) & (ctrl_rw != RW_LATCH);
            assign latch_cmd = ctrl_wr & (ctrl_sel == 2'(gi)) & (ctrl_rw == RW_LATCH);
            assign rd_sel    = rd_valid & (rd_port == 2'(gi));

            pit_channel #(
                .COUNT_WIDTH(COUNT_WIDTH)
            ) u_channel (
                .clk_i      (clk),
                .rst_i      (reset),
                .tick_i     (tick),
                .gate_i     (gate[gi]),
                .cfg_wr_i   (cfg_wr),
                .cfg_rw_i   (ctrl_rw),
                .cfg_mode_i (ctrl_mode),
                .latch_i    (latch_cmd),
                .data_wr_i  (data_wr),
                .data_i     (wr_byte),
                .rd_i       (rd_sel),
                .rd_byte_o  (rd_bytes[gi]),
                .out_o      (out[gi])
            );
        end else begin : g_absent
            assign rd_bytes[gi] = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= 16'h0000;
            ack_q      <= 1'b0;
        end else begin
            ack_q      <= bus_acc;
            data_out_q <= rd_valid ? {8'h00, rd_bytes[rd_port]} : 16'h0000;
        end
    end

    assign data_m_data_out = data_out_q;
    assign data_m_ack      = ack_q;

endmodule

// File: tb/tb_pit_timer.sv
// Directed self-checking bench for pit_timer: modes 0/2/3, gating, latch
// reads and asynchronous reset.
module tb_pit_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pit_clk;
    logic        cs, data_m_access, data_m_wr_en;
    logic [1:1]  data_m_addr;
    logic [1:0]  data_m_bytesel;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_ack;
    logic [2:0]  gate;
    logic [2:0]  out;

    int checks = 0;
    int errors = 0;
    logic [15:0] rd;

    pit_timer #(
        .NUM_CHANNELS(3),
        .COUNT_WIDTH (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pit_clk         (pit_clk),
        .cs              (cs),
        .data_m_access   (data_m_access),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_addr     (data_m_addr),
        .data_m_bytesel  (data_m_bytesel),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_ack      (data_m_ack),
        .gate            (gate),
        .out             (out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
        data_m_addr = 1'b0; data_m_bytesel = 2'b00; data_m_data_in = 16'h0000;
    endtask

    task automatic bus_write(input logic a, input logic [1:0] bs, input logic [15:0] d);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = a; data_m_bytesel = bs; data_m_data_in = d;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic a, input logic [1:0] bs, output logic [15:0] d);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
        data_m_addr = a; data_m_bytesel = bs; data_m_data_in = 16'h0000;
        @(posedge clk); #1;
        d = data_m_data_out;
        check("rd_ack", 16'(data_m_ack), 16'd1);
        bus_idle();
    endtask

    task automatic do_tick();
        pit_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 pit_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pit_clk = 1'b0; gate = 3'b111;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_out", 16'(out), 16'h0000);
        check("rst_dout", data_m_data_out, 16'h0000);
        check("rst_ack", 16'(data_m_ack), 16'h0000);
        bus_read(1'b0, 2'b01, rd);
        check("rst_rd_ch0", rd, 16'h0000);
        $display("reset checks done");

        // ch0 mode 2, reload 4 (LSB then MSB): low one tick in every four
        bus_write(1'b1, 2'b10, 16'h3400);
        check("m2_cfg_out", 16'(out[0]), 16'd1);
        bus_write(1'b0, 2'b01, 16'h0004);
        bus_write(1'b0, 2'b01, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            do_tick();
            check($sformatf("m2_out_t%0d", k), 16'(out[0]), (k % 4 == 0) ? 16'd0 : 16'd1);
        end
        $display("ch0 mode2 period checks done");

        // ch2 mode 3, reload 5: high 3, low 2
        bus_write(1'b1, 2'b10, 16'hB600);
        check("m3_cfg_out", 16'(out[2]), 16'd1);
        bus_write(1'b1, 2'b01, 16'h0005);
        bus_write(1'b1, 2'b01, 16'h0000);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            check($sformatf("m3_out_t%0d", k), 16'(out[2]), ((k - 1) % 5 < 3) ? 16'd1 : 16'd0);
        end
        gate = 3'b011;
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            check($sformatf("m3_frozen_t%0d", k), 16'(out[2]), 16'd0);
        end
        gate = 3'b111;
        for (int k = 11; k <= 14; k++) begin
            do_tick();
            check($sformatf("m3_resume_t%0d", k), 16'(out[2]), ((k - 1) % 5 < 3) ? 16'd1 : 16'd0);
        end
        $display("ch2 mode3 and gate checks done");

        // ch1 mode 0, rw=LSB, reload 3
        bus_write(1'b1, 2'b10, 16'h5000);
        check("m0_cfg_out", 16'(out[1]), 16'd0);
        bus_write(1'b0, 2'b10, 16'h0300);
        for (int k = 1; k <= 6; k++) begin
            do_tick();
            check($sformatf("m0_out_t%0d", k), 16'(out[1]), (k >= 4) ? 16'd1 : 16'd0);
        end
        bus_write(1'b0, 2'b10, 16'h0300);
        check("m0_rewrite_out", 16'(out[1]), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            check($sformatf("m0_reload_t%0d", k), 16'(out[1]), (k >= 4) ? 16'd1 : 16'd0);
        end
        // Mode code aliases: 5 behaves as mode 0, 6 as mode 2
        bus_write(1'b1, 2'b10, 16'h5A00);
        check("alias5_out", 16'(out[1]), 16'd0);
        bus_write(1'b1, 2'b10, 16'h5C00);
        check("alias6_out", 16'(out[1]), 16'd1);
        $display("ch1 mode0 and alias checks done");

        // ch0 latch: reload 0x1234, latch right after the load tick
        bus_write(1'b1, 2'b10, 16'h3400);
        bus_write(1'b0, 2'b01, 16'h0034);
        bus_write(1'b0, 2'b01, 16'h0012);
        do_tick();
        bus_write(1'b1, 2'b10, 16'h0000);
        for (int k = 0; k < 5; k++) do_tick();
        bus_read(1'b0, 2'b01, rd);
        check("latch_lsb", rd, 16'h0034);
        bus_read(1'b0, 2'b01, rd);
        check("latch_msb", rd, 16'h0012);
        bus_read(1'b0, 2'b01, rd);
        check("live_lsb", rd, 16'h002F);
        bus_read(1'b0, 2'b01, rd);
        check("live_msb", rd, 16'h0012);
        // A second latch while one is pending is ignored
        bus_write(1'b1, 2'b10, 16'h0000);
        do_tick();
        bus_write(1'b1, 2'b10, 16'h0000);
        do_tick();
        bus_read(1'b0, 2'b01, rd);
        check("relatch_lsb", rd, 16'h002F);
        bus_read(1'b0, 2'b01, rd);
        check("relatch_msb", rd, 16'h0012);
        bus_read(1'b0, 2'b01, rd);
        check("relive_lsb", rd, 16'h002D);
        bus_read(1'b1, 2'b10, rd);
        check("ctrl_read", rd, 16'h0000);
        check("m2_out_before_rst", 16'(out[0]), 16'd1);
        $display("ch0 latch checks done");

        // Asynchronous reset mid-count, in the middle of a read response
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
        data_m_addr = 1'b0; data_m_bytesel = 2'b01;
        @(posedge clk); #2;
        bus_idle();
        reset = 1'b1;
        #1;
        check("arst_out", 16'(out), 16'h0000);
        check("arst_dout", data_m_data_out, 16'h0000);
        check("arst_ack", 16'(data_m_ack), 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            check($sformatf("post_rst_out_t%0d", k), 16'(out[0]), 16'd0);
        end
        bus_read(1'b0, 2'b01, rd);
        check("post_rst_count", rd, 16'h0000);
        bus_write(1'b1, 2'b10, 16'h3400);
        bus_write(1'b0, 2'b01, 16'h0004);
        bus_write(1'b0, 2'b01, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check($sformatf("restart_out_t%0d", k), 16'(out[0]), (k % 4 == 0) ? 16'd0 : 16'd1);
        end
        $display("reset mid-count checks done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
